// File: rtl/rc4_prga_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : rc4_prga_decrypt
// Description : RC4 keystream generator (PRGA) and decrypt engine. It runs
//               after the S-array has been initialised and key-shuffled. For
//               each ciphertext byte k it performs the standard PRGA step on
//               the external 256x8 S-RAM:
//                 i = i+1, j = j+S[i], swap S[i]/S[j], f = S[S[i]+S[j]].
//               It then writes f ^ ROM[k] to the result RAM. When CHECK_VALID
//               is set, the run stops at the first plaintext byte outside
//               {a..z, space}, so a key-search controller can drop a wrong
//               key early.
//
// Parameters  : MSG_LEN     - bytes decrypted per run (1..2**MSG_ADDR_W)
//               MSG_ADDR_W  - ROM / result-RAM address width
//               CHECK_VALID - 1: abort on first non-text byte, 0: never abort
//
// Ports       : clk            in   system clock, rising edge
//               reset_n        in   asynchronous active-low reset
//               start          in   level request, sampled in IDLE
//               s_read_data    in   S-RAM read data (1-cycle latency)
//               rom_read_data  in   ciphertext ROM data (1-cycle latency)
//               s_address      out  S-RAM address
//               s_write        out  S-RAM write enable
//               s_write_data   out  S-RAM write data
//               rom_address    out  ciphertext byte index k
//               ram_address    out  result RAM address (= k)
//               ram_write      out  result RAM write enable
//               ram_write_data out  plaintext byte
//               finish         out  high in DONE until start drops
//               valid          out  in DONE: 1 = message passed, 0 = aborted
//
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_prga_decrypt #(
  parameter int MSG_LEN     = 32,
  parameter int MSG_ADDR_W  = 5,
  parameter int CHECK_VALID = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            s_read_data,
  input  logic [7:0]            rom_read_data,
  output logic [7:0]            s_address,
  output logic                  s_write,
  output logic [7:0]            s_write_data,
  output logic [MSG_ADDR_W-1:0] rom_address,
  output logic [MSG_ADDR_W-1:0] ram_address,
  output logic                  ram_write,
  output logic [7:0]            ram_write_data,
  output logic                  finish,
  output logic                  valid
);

  // One state per memory cycle of the per-byte PRGA sequence.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_I   = 4'd1;
  localparam logic [3:0] ST_LAT_I  = 4'd2;
  localparam logic [3:0] ST_RD_J   = 4'd3;
  localparam logic [3:0] ST_LAT_J  = 4'd4;
  localparam logic [3:0] ST_WR_I   = 4'd5;
  localparam logic [3:0] ST_WR_J   = 4'd6;
  localparam logic [3:0] ST_RD_F   = 4'd7;
  localparam logic [3:0] ST_LAT_F  = 4'd8;
  localparam logic [3:0] ST_WR_OUT = 4'd9;
  localparam logic [3:0] ST_DONE   = 4'd10;

  localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LEN - 1);

  logic [3:0]            state_q, state_d;
  logic [7:0]            i_q, i_d;
  logic [7:0]            j_q, j_d;
  logic [MSG_ADDR_W-1:0] k_q, k_d;
  logic [7:0]            si_q, si_d;
  logic [7:0]            sj_q, sj_d;
  logic [7:0]            f_q, f_d;
  logic [7:0]            c_q, c_d;      // ciphertext byte captured with f
  logic                  valid_q, valid_d;

  logic [7:0]            plain_byte;
  logic                  byte_ok;

  assign plain_byte = f_q ^ c_q;

  // Validity filter: lowercase letters or space. It is compiled out
  // entirely when early abort is not wanted.
  generate
    if (CHECK_VALID != 0) begin : g_check_valid
      assign byte_ok = ((plain_byte >= 8'h61) && (plain_byte <= 8'h7A)) ||
                       (plain_byte == 8'h20);
    end else begin : g_no_check
      assign byte_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    j_d            = j_q;
    k_d            = k_q;
    si_d           = si_q;
    sj_d           = sj_q;
    f_d            = f_q;
    c_d            = c_q;
    valid_d        = valid_q;

    // Outputs idle at zero outside the cycle that uses them, so
    // IDLE (and therefore reset) drives every output low.
    s_address      = 8'd0;
    s_write        = 1'b0;
    s_write_data   = 8'd0;
    rom_address    = '0;
    ram_address    = '0;
    ram_write      = 1'b0;
    ram_write_data = 8'd0;
    finish         = 1'b0;
    valid          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = '0;
          valid_d = 1'b0;
          state_d = ST_RD_I;
        end
      end

      ST_RD_I: begin
        i_d       = i_q + 8'd1;
        s_address = i_q + 8'd1;
        state_d   = ST_LAT_I;
      end

      ST_LAT_I: begin
        si_d    = s_read_data;
        j_d     = j_q + s_read_data;
        state_d = ST_RD_J;
      end

      ST_RD_J: begin
        s_address = j_q;
        state_d   = ST_LAT_J;
      end

      ST_LAT_J: begin
        sj_d    = s_read_data;
        state_d = ST_WR_I;
      end

      // Swap is two writes. When i == j both hit the same cell, and the
      // second write stores si (== sj), so S is left unchanged as required.
      ST_WR_I: begin
        s_address    = i_q;
        s_write_data = sj_q;
        s_write      = 1'b1;
        state_d      = ST_WR_J;
      end

      ST_WR_J: begin
        s_address    = j_q;
        s_write_data = si_q;
        s_write      = 1'b1;
        state_d      = ST_RD_F;
      end

      // The keystream index is read from the already-swapped S, and the
      // 8-bit sum wraps naturally.
      ST_RD_F: begin
        s_address   = si_q + sj_q;
        rom_address = k_q;
        state_d     = ST_LAT_F;
      end

      ST_LAT_F: begin
        f_d     = s_read_data;
        c_d     = rom_read_data;
        state_d = ST_WR_OUT;
      end

      // The byte is always written, even the one that triggers an abort.
      ST_WR_OUT: begin
        ram_address    = k_q;
        ram_write_data = plain_byte;
        ram_write      = 1'b1;
        if (!byte_ok) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else if (k_q == K_LAST) begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_RD_I;
        end
      end

      // Hold the result until the requester drops start. Because the
      // request is a level, a new run needs start to go low and then high.
      ST_DONE: begin
        finish = 1'b1;
        valid  = valid_q;
        if (!start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= '0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      c_q     <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_prga_decrypt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rc4_prga_decrypt
// Description : Self-checking bench for rc4_prga_decrypt. It has three
//               instances:
//                 u_dut0 - CHECK_VALID=0, 32 bytes, constant memory data
//                 u_dut1 - CHECK_VALID=1, 32 bytes, constant or behavioural
//                          S-RAM / ROM
//                 u_dut2 - CHECK_VALID=1, 8 bytes, behavioural memories
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start0, start1, start2;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance 0: constant stimulus, no validity check -------
  logic [7:0] s_address0, s_wdata0, ram_wdata0;
  logic       s_write0, ram_write0, finish0, valid0;
  logic [4:0] rom_addr0, ram_addr0;

  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_ADDR_W(5), .CHECK_VALID(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0),
    .s_read_data(8'hAA), .rom_read_data(8'h55),
    .s_address(s_address0), .s_write(s_write0), .s_write_data(s_wdata0),
    .rom_address(rom_addr0), .ram_address(ram_addr0), .ram_write(ram_write0),
    .ram_write_data(ram_wdata0), .finish(finish0), .valid(valid0));

  // ---------------- instance 1: 32 bytes, validity check ------------------
  logic [7:0] s_address1, s_wdata1, ram_wdata1, s_rd1, rom_rd1;
  logic       s_write1, ram_write1, finish1, valid1;
  logic [4:0] rom_addr1, ram_addr1;
  logic       const1, load1, clr1;
  logic [7:0] sram1 [256];
  logic [7:0] rom1  [32];
  logic [7:0] res1  [32];
  logic [7:0] sram1_q, rom1_q;

  assign s_rd1   = const1 ? 8'hAA : sram1_q;
  assign rom_rd1 = const1 ? 8'h55 : rom1_q;

  rc4_prga_decrypt #(.MSG_LEN(32), .MSG_ADDR_W(5), .CHECK_VALID(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .s_read_data(s_rd1), .rom_read_data(rom_rd1),
    .s_address(s_address1), .s_write(s_write1), .s_write_data(s_wdata1),
    .rom_address(rom_addr1), .ram_address(ram_addr1), .ram_write(ram_write1),
    .ram_write_data(ram_wdata1), .finish(finish1), .valid(valid1));

  // ---------------- instance 2: 8 bytes, validity check -------------------
  logic [7:0] s_address2, s_wdata2, ram_wdata2, sram2_q, rom2_q;
  logic       s_write2, ram_write2, finish2, valid2;
  logic [2:0] rom_addr2, ram_addr2;
  logic       load2;
  logic [7:0] sram2 [256];
  logic [7:0] rom2  [8];
  logic [7:0] res2  [8];

  rc4_prga_decrypt #(.MSG_LEN(8), .MSG_ADDR_W(3), .CHECK_VALID(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .s_read_data(sram2_q), .rom_read_data(rom2_q),
    .s_address(s_address2), .s_write(s_write2), .s_write_data(s_wdata2),
    .rom_address(rom_addr2), .ram_address(ram_addr2), .ram_write(ram_write2),
    .ram_write_data(ram_wdata2), .finish(finish2), .valid(valid2));

  // ---------------- behavioural memories and monitors ---------------------
  int wr_cnt0 = 0, err0 = 0;
  int wr_cnt1 = 0, ovl1 = 0;
  int wr_cnt2 = 0, max_addr2 = 0;

  always @(posedge clk) begin
    if (ram_write0) begin
      if (ram_addr0 != 5'(wr_cnt0) || ram_wdata0 != 8'hFF) err0 <= err0 + 1;
      wr_cnt0 <= wr_cnt0 + 1;
    end
  end

  always @(posedge clk) begin
    if (load1) begin
      for (int x = 0; x < 256; x++) sram1[x] <= 8'(x);
    end else if (s_write1) begin
      sram1[s_address1] <= s_wdata1;
    end
    sram1_q <= sram1[s_address1];
    rom1_q  <= rom1[rom_addr1];
    if (clr1) begin
      wr_cnt1 <= 0;
      ovl1    <= 0;
      for (int x = 0; x < 32; x++) res1[x] <= 8'h00;
    end else begin
      if (ram_write1) begin
        wr_cnt1         <= wr_cnt1 + 1;
        res1[ram_addr1] <= ram_wdata1;
      end
      if (ram_write1 && s_write1) ovl1 <= ovl1 + 1;
    end
  end

  always @(posedge clk) begin
    if (load2) begin
      for (int x = 0; x < 256; x++) sram2[x] <= 8'(x);
    end else if (s_write2) begin
      sram2[s_address2] <= s_wdata2;
    end
    sram2_q <= sram2[s_address2];
    rom2_q  <= rom2[rom_addr2];
    if (ram_write2) begin
      wr_cnt2         <= wr_cnt2 + 1;
      res2[ram_addr2] <= ram_wdata2;
    end
    if (int'(rom_addr2) > max_addr2) max_addr2 <= int'(rom_addr2);
    if (int'(ram_addr2) > max_addr2) max_addr2 <= int'(ram_addr2);
  end

  // ---------------- reference RC4 PRGA from identity S --------------------
  logic [7:0] ms [256];
  logic [7:0] ks [32];

  task automatic rc4_model(input int n);
    logic [7:0] i, j, t;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    i = 8'd0;
    j = 8'd0;
    for (int b = 0; b < n; b++) begin
      i     = i + 8'd1;
      j     = j + ms[i];
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
      t     = ms[i] + ms[j];
      ks[b] = ms[t];
    end
  endtask

  // ---------------- checking and run helpers ------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic fin_of(input int d);
    case (d)
      0:       return finish0;
      1:       return finish1;
      default: return finish2;
    endcase
  endfunction

  // Counts edges after the current one until finish is high. The edge that
  // sampled start is cycle 1.
  task automatic wait_fin(input int d, input int budget, output int cyc);
    int n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      seen = fin_of(d);
    end
    if (!seen) check_eq("finish_timeout", 32'(seen), 32'd1);
    cyc = n + 1;
  endtask

  task automatic run_dut(input int d, input int budget, output int cyc);
    @(negedge clk);
    set_start(d, 1'b1);
    @(posedge clk);
    wait_fin(d, budget, cyc);
  endtask

  logic [8*32-1:0] txt1;
  logic [8*8-1:0]  txt2;
  int cyc, bad;

  initial begin
    txt1    = "abcdefghijklmnopqrstuvwxyzabcdef";
    txt2    = "hello wo";
    reset_n = 1'b0;
    start0  = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    const1  = 1'b1;
    load1   = 1'b1;
    load2   = 1'b1;
    clr1    = 1'b1;
    for (int x = 0; x < 32; x++) rom1[x] = 8'h00;
    for (int x = 0; x < 8; x++) rom2[x] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out0", 32'(|{s_address0, s_write0, s_wdata0, rom_addr0, ram_addr0,
                               ram_write0, ram_wdata0, finish0, valid0}), 32'd0);
    check_eq("rst_out1", 32'(|{s_address1, s_write1, s_wdata1, rom_addr1, ram_addr1,
                               ram_write1, ram_wdata1, finish1, valid1}), 32'd0);
    check_eq("rst_out2", 32'(|{s_address2, s_write2, s_wdata2, rom_addr2, ram_addr2,
                               ram_write2, ram_wdata2, finish2, valid2}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    load1   = 1'b0;
    load2   = 1'b0;
    clr1    = 1'b0;

    // Constant S=0xAA, ROM=0x55: every plaintext byte is 0xFF.
    run_dut(0, 400, cyc);
    check_eq("c0_cycles", 32'(cyc), 32'd289);
    check_eq("c0_valid", 32'(valid0), 32'd1);
    check_eq("c0_writes", 32'(wr_cnt0), 32'd32);
    check_eq("c0_wr_errs", 32'(err0), 32'd0);
    @(negedge clk) start0 = 1'b0;

    // The same stimulus with the check enabled aborts on byte 0.
    run_dut(1, 400, cyc);
    check_eq("c1_cycles", 32'(cyc), 32'd10);
    check_eq("c1_valid", 32'(valid1), 32'd0);
    check_eq("c1_writes", 32'(wr_cnt1), 32'd1);
    check_eq("c1_byte0", 32'(res1[0]), 32'h0000_00FF);
    @(negedge clk) start1 = 1'b0;

    // Identity S. ROM = keystream ^ text, so RAM must end up holding the text.
    rc4_model(32);
    for (int k = 0; k < 32; k++) rom1[k] = ks[k] ^ txt1[8*(31-k) +: 8];
    @(negedge clk) begin const1 = 1'b0; load1 = 1'b1; clr1 = 1'b1; end
    @(negedge clk) begin load1 = 1'b0; clr1 = 1'b0; end
    run_dut(1, 400, cyc);
    check_eq("txt_cycles", 32'(cyc), 32'd289);
    check_eq("txt_valid", 32'(valid1), 32'd1);
    check_eq("txt_writes", 32'(wr_cnt1), 32'd32);
    bad = 0;
    for (int k = 0; k < 32; k++) if (res1[k] != txt1[8*(31-k) +: 8]) bad++;
    check_eq("txt_plain", 32'(bad), 32'd0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (sram1[x] != ms[x]) bad++;
    check_eq("txt_final_s", 32'(bad), 32'd0);
    check_eq("txt_overlap", 32'(ovl1), 32'd0);

    // Holding start keeps DONE and produces no writes.
    repeat (20) @(posedge clk);
    #1;
    check_eq("hold_finish", 32'(finish1), 32'd1);
    check_eq("hold_writes", 32'(wr_cnt1), 32'd32);
    @(negedge clk) begin load1 = 1'b1; clr1 = 1'b1; end
    @(negedge clk) begin load1 = 1'b0; clr1 = 1'b0; start1 = 1'b0; end
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rerun_finish_low", 32'(finish1), 32'd0);
    wait_fin(1, 400, cyc);
    check_eq("rerun_cycles", 32'(cyc), 32'd289);
    check_eq("rerun_valid", 32'(valid1), 32'd1);

    // Asynchronous reset in LAT_J of the third byte, then a clean restart.
    @(negedge clk) begin start1 = 1'b0; load1 = 1'b1; clr1 = 1'b1; end
    @(negedge clk) begin load1 = 1'b0; clr1 = 1'b0; start1 = 1'b1; end
    @(posedge clk);
    repeat (21) @(posedge clk);
    #1;
    check_eq("pre_rst_writes", 32'(wr_cnt1), 32'd2);
    reset_n = 1'b0;
    start1  = 1'b0;
    #1;
    check_eq("arst_out1", 32'(|{s_address1, s_write1, s_wdata1, rom_addr1, ram_addr1,
                                ram_write1, ram_wdata1, finish1, valid1}), 32'd0);
    #1;
    reset_n = 1'b1;
    @(negedge clk) begin load1 = 1'b1; clr1 = 1'b1; end
    @(negedge clk) begin load1 = 1'b0; clr1 = 1'b0; end
    run_dut(1, 400, cyc);
    check_eq("arst_cycles", 32'(cyc), 32'd289);
    check_eq("arst_valid", 32'(valid1), 32'd1);
    bad = 0;
    for (int k = 0; k < 32; k++) if (res1[k] != txt1[8*(31-k) +: 8]) bad++;
    check_eq("arst_plain", 32'(bad), 32'd0);
    @(negedge clk) start1 = 1'b0;

    // 8-byte message containing a space.
    rc4_model(8);
    for (int k = 0; k < 8; k++) rom2[k] = ks[k] ^ txt2[8*(7-k) +: 8];
    run_dut(2, 200, cyc);
    check_eq("m8_cycles", 32'(cyc), 32'd73);
    check_eq("m8_valid", 32'(valid2), 32'd1);
    check_eq("m8_writes", 32'(wr_cnt2), 32'd8);
    check_eq("m8_max_addr", 32'(max_addr2), 32'd7);
    bad = 0;
    for (int k = 0; k < 8; k++) if (res2[k] != txt2[8*(7-k) +: 8]) bad++;
    check_eq("m8_plain", 32'(bad), 32'd0);
    @(negedge clk) start2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
Parametrised RC4 keystream (PRGA) and decrypt engine. It runs after the S-array init/shuffle stages. It reads and swaps S in the 256x8 S-RAM, XORs each keystream byte with the ciphertext ROM, and writes plaintext to the result RAM. It generalises the fixed 32-byte decrypt stage in three ways: configurable message length, an asynchronous reset, and an optional plaintext-validity check with early abort. The validity check lets the key-search controller reject a key as soon as possible.

Parameters:
MSG_LEN, 32, number of message bytes decrypted per run (1..2**MSG_ADDR_W)
MSG_ADDR_W, 5, width of ROM/result-RAM address
CHECK_VALID, 1, 1 = abort at first byte outside {0x61..0x7A, 0x20}; 0 = always decrypt all bytes

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  level request; run begins when sampled high in IDLE
s_read_data  in  8  S-RAM read data, valid the cycle after the address is presented
rom_read_data  in  8  ciphertext ROM read data, same 1-cycle latency
s_address  out  8  S-RAM address
s_write  out  1  S-RAM write enable
s_write_data  out  8  S-RAM write data
rom_address  out  MSG_ADDR_W  ciphertext byte index k
ram_address  out  MSG_ADDR_W  result RAM address (= k)
ram_write  out  1  result RAM write enable
ram_write_data  out  8  plaintext byte
finish  out  1  high in DONE until start drops
valid  out  1  in DONE: 1 = all bytes passed check (or CHECK_VALID=0), 0 = aborted

Behaviour:
- One clock domain. reset_n is asynchronous and active-low.
- Reset, at any time including mid-run: state=IDLE, i=j=k=0, latches cleared. All outputs are 0: s_address, s_write, s_write_data, rom_address, ram_address, ram_write, ram_write_data, finish, valid.
- Internal registers: i, j (8 bit, mod 256), k (MSG_ADDR_W bit), si, sj, f (8 bit).
- IDLE: if start=1, then i<=0, j<=0, k<=0 and go to RD_I.
- Per byte, 9 states, one cycle each:
  - RD_I: i<=i+1; s_address=i+1.
  - LAT_I: si<=s_read_data; j<=j+s_read_data.
  - RD_J: s_address=j.
  - LAT_J: sj<=s_read_data.
  - WR_I: s_address=i, s_write_data=sj, s_write=1.
  - WR_J: s_address=j, s_write_data=si, s_write=1.
  - RD_F: s_address=(si+sj) mod 256; rom_address=k.
  - LAT_F: f<=s_read_data; capture rom_read_data.
  - WR_OUT: ram_address=k, ram_write_data=f^rom, ram_write=1.
- After WR_OUT:
  - If CHECK_VALID=1 and the byte is not in a..z or space: valid<=0, go to DONE.
  - Else if k==MSG_LEN-1: valid<=1, go to DONE.
  - Else k<=k+1, go to RD_I.
- The failing byte is still written before the abort.
- Latency: a full run occupies 9*MSG_LEN cycles after start is sampled. finish rises on the next edge (cycle 9*MSG_LEN+1).
- DONE: finish=1, valid held, no memory writes. The block stays in DONE while start=1 and returns to IDLE on start=0. A new run needs start to go low, then high.
- s_write and ram_write are never asserted together, and each is high for exactly one cycle per write.
- i==j: WR_I and WR_J target the same address. The WR_J value lands last; it equals si, which equals sj, so S is unchanged.
- Wrap: i and j wrap 255->0, and the si+sj sum is truncated to 8 bits. k never exceeds MSG_LEN-1.
- A start change during a run is ignored until DONE.

Test Plan:
- CHECK_VALID=0, s_read_data held 0xAA, rom_read_data 0x55 -> 32 ram_writes of 0xFF at addresses 0..31; finish at cycle 289; valid=1.
- Same stimulus with CHECK_VALID=1 -> exactly one ram_write (addr 0, 0xFF); finish at cycle 10; valid=0.
- Behavioural S-RAM with S[x]=x and ROM = golden keystream XOR "abcd…" -> RAM holds the expected ASCII string; valid=1; final S matches the software RC4 model. Covers i==j at the first byte (i=j=1).
- MSG_LEN=8, MSG_ADDR_W=3, valid text with a space at byte 5 -> 8 writes; rom_address/ram_address never exceed 7; finish at cycle 73.
- reset_n pulsed low during LAT_J of byte 3 -> all outputs 0 immediately (async); restart recomputes from i=j=0 and produces correct plaintext.
- start held high after DONE -> finish stays 1 with no new writes. start low for one cycle, then high -> new run begins and finish drops.
